// File: rtl/nv_nvdla_sdp_core_gather_pkg.sv
// Shared SDP gather definitions: counter width and the legal beat-ratio check.
package nv_nvdla_sdp_core_gather_pkg;

  localparam int unsigned SDP_GATHER_CNT_W = 4;

  function automatic logic sdp_ratio_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8) || (r == 16);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_gather_oreg.sv
// One-entry valid/ready output register: load on transfer, hold under stall, drain on accept.
module nv_nvdla_sdp_gather_oreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         out_prdy,
  output logic         out_pvld,
  output logic [W-1:0] out_data
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = in_data;
    end else if (vld_q && out_prdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_pvld = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/nv_nvdla_sdp_core_gather.sv
// Narrow-to-wide beat gatherer: packs RATIO IW-bit beats (beat 0 in the LSBs) into one OW-bit word.
module nv_nvdla_sdp_core_gather
  import nv_nvdla_sdp_core_gather_pkg::*;
#(
  parameter int unsigned IW    = 128,
  parameter int unsigned OW    = 512,
  parameter int unsigned RATIO = OW / IW
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              inp_pvld,
  output logic              inp_prdy,
  input  logic [IW-1:0]     inp_data,
  input  logic              inp_last,
  output logic              out_pvld,
  input  logic              out_prdy,
  output logic [OW-1:0]     out_data,
  output logic [RATIO-1:0]  out_mask
);

  localparam int unsigned       CW       = SDP_GATHER_CNT_W;
  localparam logic [CW-1:0]     LAST_SEG = CW'(RATIO - 1);

  if (!sdp_ratio_legal(int'(RATIO))) begin : g_ratio_chk
    $error("nv_nvdla_sdp_core_gather: RATIO must be 1, 2, 4, 8 or 16");
  end

  logic [OW-1:0]       acc_q;
  logic [OW-1:0]       acc_d;
  logic [RATIO-1:0]    acc_mask_q;
  logic [RATIO-1:0]    acc_mask_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                acc_full_q;
  logic                acc_full_d;

  logic                inp_acc;
  logic                word_done;
  logic                xfer;
  logic [OW+RATIO-1:0] oreg_data;

  // A full accumulator can still take a beat when it empties into the output register this cycle.
  assign inp_prdy  = !nvdla_core_rst & (!acc_full_q | !out_pvld | out_prdy);
  assign inp_acc   = inp_pvld & inp_prdy;
  assign xfer      = acc_full_q & (!out_pvld | out_prdy);
  assign word_done = inp_acc & ((cnt_q == LAST_SEG) | inp_last);

  always_comb begin
    cnt_d      = cnt_q;
    acc_full_d = acc_full_q;
    if (xfer) begin
      acc_full_d = 1'b0;
    end
    if (word_done) begin
      acc_full_d = 1'b1;
      cnt_d      = '0;
    end else if (inp_acc) begin
      cnt_d      = cnt_q + CW'(1);
    end
  end

  // Segment 0 of a new word clears the remaining segments so short words come out zero-filled.
  for (genvar k = 0; k < int'(RATIO); k++) begin : g_seg
    logic          seg_wr;
    logic          seg_clr;
    logic [IW-1:0] seg_d;
    logic          mask_d;

    assign seg_wr  = inp_acc & (cnt_q == CW'(k));
    assign seg_clr = inp_acc & (cnt_q == '0) & (k != 0);

    always_comb begin
      seg_d  = acc_q[k*IW +: IW];
      mask_d = acc_mask_q[k];
      if (seg_wr) begin
        seg_d  = inp_data;
        mask_d = 1'b1;
      end else if (seg_clr) begin
        seg_d  = '0;
        mask_d = 1'b0;
      end
    end

    assign acc_d[k*IW +: IW] = seg_d;
    assign acc_mask_d[k]     = mask_d;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      acc_q      <= '0;
      acc_mask_q <= '0;
      cnt_q      <= '0;
      acc_full_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_mask_q <= acc_mask_d;
      cnt_q      <= cnt_d;
      acc_full_q <= acc_full_d;
    end
  end

  nv_nvdla_sdp_gather_oreg #(
    .W (OW + RATIO)
  ) u_oreg (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .load     (xfer),
    .in_data  ({acc_mask_q, acc_q}),
    .out_prdy (out_prdy),
    .out_pvld (out_pvld),
    .out_data (oreg_data)
  );

  assign out_data = oreg_data[OW-1:0];
  assign out_mask = oreg_data[OW +: RATIO];

endmodule

// File: tb/tb_nv_nvdla_sdp_core_gather.sv
// Self-checking bench for the SDP beat gatherer at RATIO=4 and RATIO=1.
module tb_nv_nvdla_sdp_core_gather;

  typedef struct packed {
    logic [511:0] data;
    logic [3:0]   mask;
  } exp4_t;

  typedef struct packed {
    int unsigned          n;
    logic                 lst;
    logic [3:0][127:0]    b;
    logic [511:0]         exp_data;
    logic [3:0]           exp_mask;
  } vec_t;

  logic         clk;
  logic         rst4, pvld4, prdy4, last4, opvld4, oprdy4;
  logic [127:0] data4;
  logic [511:0] odata4;
  logic [3:0]   omask4;
  logic         rst1, pvld1, prdy1, last1, opvld1, oprdy1;
  logic [127:0] data1;
  logic [127:0] odata1;
  logic [0:0]   omask1;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  int unsigned  n_words4 = 0;
  exp4_t        q4[$];
  logic [127:0] q1[$];
  exp4_t        mon_e4;
  logic [127:0] mon_e1;
  vec_t         tbl[6];

  nv_nvdla_sdp_core_gather #(.IW(128), .OW(512)) u_dut4 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst4),
    .inp_pvld       (pvld4),
    .inp_prdy       (prdy4),
    .inp_data       (data4),
    .inp_last       (last4),
    .out_pvld       (opvld4),
    .out_prdy       (oprdy4),
    .out_data       (odata4),
    .out_mask       (omask4)
  );

  nv_nvdla_sdp_core_gather #(.IW(128), .OW(128)) u_dut1 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst1),
    .inp_pvld       (pvld1),
    .inp_prdy       (prdy1),
    .inp_data       (data1),
    .inp_last       (last1),
    .out_pvld       (opvld1),
    .out_prdy       (oprdy1),
    .out_data       (odata1),
    .out_mask       (omask1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] st_beat(input int k);
    return {4{32'hC000_0000 + 32'(k)}};
  endfunction

  function automatic logic [127:0] bp_beat(input int k);
    return {4{32'hB000_0000 + 32'(k)}};
  endfunction

  task automatic send4(input logic [127:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    pvld4 = 1'b1; data4 = d; last4 = l;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = prdy4;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL send4_timeout: got no inp_prdy expected accept within 100 cycles");
    end else begin
      @(posedge clk); #1;
    end
    pvld4 = 1'b0; last4 = 1'b0;
  endtask

  task automatic send1(input logic [127:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    pvld1 = 1'b1; data1 = d; last1 = l;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = prdy1;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL send1_timeout: got no inp_prdy expected accept within 100 cycles");
    end else begin
      @(posedge clk); #1;
    end
    pvld1 = 1'b0; last1 = 1'b0;
  endtask

  // Output scoreboards: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (opvld4 === 1'b1 && oprdy4 === 1'b1 && rst4 === 1'b0) begin
      if (q4.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out4_unexpected: got word %0h expected none", odata4);
      end else begin
        mon_e4 = q4.pop_front();
        chk("out4_data", odata4, mon_e4.data);
        chk("out4_mask", 512'(omask4), 512'(mon_e4.mask));
        n_words4++;
      end
    end
  end

  always @(negedge clk) begin
    if (opvld1 === 1'b1 && oprdy1 === 1'b1 && rst1 === 1'b0) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out1_unexpected: got word %0h expected none", odata1);
      end else begin
        mon_e1 = q1.pop_front();
        chk("out1_data", 512'(odata1), 512'(mon_e1));
        chk("out1_mask", 512'(omask1), 512'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc_n, low, nw, bad, w0;
    int          last_c;
    int          k;
    logic        seen;
    logic [127:0] r1;

    rst4 = 1'b1; rst1 = 1'b1;
    pvld4 = 1'b0; data4 = '0; last4 = 1'b0; oprdy4 = 1'b1;
    pvld1 = 1'b0; data1 = '0; last1 = 1'b0; oprdy1 = 1'b1;

    tbl[0].n = 2; tbl[0].lst = 1'b1;
    tbl[0].b = {128'h0, 128'h0, {8{16'hBBB2}}, {8{16'hAAA1}}};
    tbl[0].exp_data = {128'h0, 128'h0, {8{16'hBBB2}}, {8{16'hAAA1}}}; tbl[0].exp_mask = 4'b0011;
    tbl[1].n = 1; tbl[1].lst = 1'b1;
    tbl[1].b = {128'h0, 128'h0, 128'h0, {8{16'hCCC3}}};
    tbl[1].exp_data = {384'h0, {8{16'hCCC3}}}; tbl[1].exp_mask = 4'b0001;
    tbl[2].n = 3; tbl[2].lst = 1'b1;
    tbl[2].b = {128'h0, {8{16'hF006}}, {8{16'hE005}}, {8{16'hD004}}};
    tbl[2].exp_data = {128'h0, {8{16'hF006}}, {8{16'hE005}}, {8{16'hD004}}}; tbl[2].exp_mask = 4'b0111;
    tbl[3].n = 4; tbl[3].lst = 1'b1;
    tbl[3].b = {{8{16'h4A0A}}, {8{16'h3909}}, {8{16'h2808}}, {8{16'h1707}}};
    tbl[3].exp_data = {{8{16'h4A0A}}, {8{16'h3909}}, {8{16'h2808}}, {8{16'h1707}}}; tbl[3].exp_mask = 4'b1111;
    tbl[4].n = 4; tbl[4].lst = 1'b0;
    tbl[4].b = {{8{16'h0D0D}}, {8{16'h0C0C}}, {8{16'h0B0B}}, {8{16'h5A5A}}};
    tbl[4].exp_data = {{8{16'h0D0D}}, {8{16'h0C0C}}, {8{16'h0B0B}}, {8{16'h5A5A}}}; tbl[4].exp_mask = 4'b1111;
    tbl[5].n = 1; tbl[5].lst = 1'b1;
    tbl[5].b = {128'h0, 128'h0, 128'h0, {8{16'h7E7E}}};
    tbl[5].exp_data = {384'h0, {8{16'h7E7E}}}; tbl[5].exp_mask = 4'b0001;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_pvld", 512'(opvld4), 512'(0));
    chk("rst_out_data", odata4, 512'(0));
    chk("rst_out_mask", 512'(omask4), 512'(0));
    chk("rst_inp_prdy4", 512'(prdy4), 512'(0));
    chk("rst_inp_prdy1", 512'(prdy1), 512'(0));
    @(posedge clk); #1;
    rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("post_rst_inp_prdy", 512'(prdy4), 512'(1));
    @(posedge clk); #1;

    // Full word back-to-back, then latency and single-cycle valid
    q4.push_back('{data: {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}}, mask: 4'b1111});
    send4({16{8'h11}}, 1'b0);
    send4({16{8'h22}}, 1'b0);
    send4({16{8'h33}}, 1'b0);
    send4({16{8'h44}}, 1'b0);
    @(negedge clk); chk("lat_pvld_t1", 512'(opvld4), 512'(0));
    @(negedge clk); chk("lat_pvld_t2", 512'(opvld4), 512'(1));
    @(negedge clk); chk("lat_pvld_t3", 512'(opvld4), 512'(0));
    @(posedge clk); #1;

    // Table of words, short ones terminated by inp_last
    for (int i = 0; i < 6; i++) begin
      q4.push_back('{data: tbl[i].exp_data, mask: tbl[i].exp_mask});
      for (int j = 0; j < int'(tbl[i].n); j++)
        send4(tbl[i].b[j], tbl[i].lst && (j == int'(tbl[i].n) - 1));
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Backpressure: two words buffered, then release
    for (int w = 0; w < 3; w++)
      q4.push_back('{data: {bp_beat(4*w+3), bp_beat(4*w+2), bp_beat(4*w+1), bp_beat(4*w)}, mask: 4'b1111});
    w0 = n_words4;
    oprdy4 = 1'b0;
    acc_n = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      pvld4 = (acc_n < 12);
      data4 = bp_beat(int'(acc_n));
      @(negedge clk);
      if (acc_n == 8 && !seen) begin
        chk("bp_prdy_after_8th", 512'(prdy4), 512'(0));
        seen = 1'b1;
      end
      if (pvld4 && prdy4) acc_n++;
      @(posedge clk); #1;
    end
    pvld4 = 1'b0;
    chk("bp_accepted", 512'(acc_n), 512'(8));
    chk("bp_no_output_stalled", 512'(n_words4 - w0), 512'(0));
    oprdy4 = 1'b1;
    for (int i = 8; i < 12; i++) send4(bp_beat(i), 1'b0);
    repeat (6) @(negedge clk);
    chk("bp_words_out", 512'(n_words4 - w0), 512'(3));
    @(posedge clk); #1;

    // Continuous streaming
    for (int w = 0; w < 10; w++)
      q4.push_back('{data: {st_beat(4*w+3), st_beat(4*w+2), st_beat(4*w+1), st_beat(4*w)}, mask: 4'b1111});
    k = 0; low = 0; nw = 0; bad = 0; last_c = -1;
    for (int c = 0; c < 60; c++) begin
      pvld4 = (k < 40);
      data4 = st_beat(k);
      @(negedge clk);
      if (k < 40 && !prdy4) low++;
      if (opvld4) begin
        nw++;
        if (last_c >= 0 && c - last_c != 4) bad++;
        last_c = c;
      end
      if (k < 40 && prdy4) k++;
      @(posedge clk); #1;
    end
    pvld4 = 1'b0;
    chk("stream_beats", 512'(k), 512'(40));
    chk("stream_prdy_low", 512'(low), 512'(0));
    chk("stream_words", 512'(nw), 512'(10));
    chk("stream_gap", 512'(bad), 512'(0));

    // Reset mid-word discards the partial word
    send4({4{32'hDEAD_0001}}, 1'b0);
    send4({4{32'hDEAD_0002}}, 1'b0);
    rst4 = 1'b1;
    @(negedge clk);
    chk("midrst_prdy", 512'(prdy4), 512'(0));
    @(posedge clk); #1;
    rst4 = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (opvld4 !== 1'b0) bad++;
    end
    chk("midrst_no_output", 512'(bad), 512'(0));
    @(posedge clk); #1;
    q4.push_back('{data: {{4{32'h5EED_0003}}, {4{32'h5EED_0002}}, {4{32'h5EED_0001}}, {4{32'h5EED_0000}}}, mask: 4'b1111});
    for (int i = 0; i < 4; i++) send4({4{32'h5EED_0000 + 32'(i)}}, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    // RATIO=1: every beat is a word regardless of inp_last
    for (int i = 0; i < 3; i++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      q1.push_back(r1);
      send1(r1, 1'($urandom_range(0, 1)));
    end
    repeat (6) @(negedge clk);

    chk("q4_drained", 512'(q4.size()), 512'(0));
    chk("q1_drained", 512'(q1.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
